echo_distance: RTL and testbench
================================

# echo_distance

Downstream consumer of the ultrasonic ranging front end. It receives the trigger stage's start pulse and the raw Echo pin, and measures the Echo high time in microseconds using a prescaled clock tick. It converts that time to centimetres with a sequential divide-by-subtraction, then publishes a one-cycle-valid distance word, a timeout flag and a proximity flag for the display/LED logic.

## Interface
- CLK_PER_US, 50: clk cycles per 1 µs tick (50 MHz board clock).
- US_PER_CM, 58: µs of echo per cm of range (round trip); the divisor.
- MAX_US, 30000: echo wait/width limit in µs; reaching it ends the cycle with timeout.
- NEAR_CM, 20: near asserts when distance_cm < NEAR_CM.
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle pulse from the trigger stage when the 10 µs trigger pulse ends.
- Echo  input  1  raw sensor echo pin, asynchronous to clk.
- distance_cm  output  10  last measured distance, floor(us_count / US_PER_CM); held between results.
- valid  output  1  one-cycle pulse when distance_cm/timeout/near update.
- timeout  output  1  1 if the last cycle timed out; held.
- near  output  1  1 if the last result was valid, not timed out, and distance_cm < NEAR_CM; held.
- busy  output  1  1 whenever the FSM is not in IDLE.

## Operation
- Echo passes through a 2-flop synchronizer (echo_s = second flop). Logic only ever uses echo_s.
- Prescaler counts 0..CLK_PER_US-1 and emits tick when it equals CLK_PER_US-1. It clears to 0 on every state entry.
- us_count is 15 bits. It clears on entry to ARM and to MEASURE, increments on tick, and saturates at MAX_US.
- States:
  - IDLE: start=1 moves to ARM. start in any other state is ignored.
  - ARM: waits for an echo_s rising edge (echo_s=1 while the previous echo_s=0). An echo already high at start is stale and is not accepted; ARM waits for a fresh rise. Rise moves to MEASURE. us_count==MAX_US moves to DONE with timeout.
  - MEASURE: counts µs while echo_s=1. echo_s=0 moves to DIVIDE, loading rem=us_count and q=0. us_count==MAX_US (echo stuck high) moves to DONE with timeout.
  - DIVIDE: one step per clk. If rem >= US_PER_CM, then rem -= US_PER_CM and q += 1. Otherwise move to DONE with no timeout. q is 10 bits; the max is 30000/58 = 517, so q never overflows.
  - DONE: lasts exactly one cycle, then returns to IDLE.
- Output updates happen on the clk edge that enters DONE:
  - Normal result: distance_cm=q, timeout=0, near=(q < NEAR_CM).
  - Timeout: distance_cm=0, timeout=1, near=0.
- valid is registered and is 1 exactly while the state is DONE.
- Reset, at any time including mid-measure or mid-divide:
  - State returns to IDLE.
  - distance_cm=0, valid=0, timeout=0, near=0, busy=0.
  - Prescaler, us_count, rem, q and the synchronizer all clear.
  - No valid pulse is produced for the aborted cycle.
- Simultaneous events:
  - Tick on the same edge that echo_s falls: the tick is counted, then the FSM leaves MEASURE.
  - echo_s rise on the same edge that ARM hits MAX_US: the timeout wins.

## Timing
- Synchronizer latency: 2 clk.
- Let k be the first clk edge that samples the Echo pin low after its high phase:
  - echo_s goes low after edge k+1.
  - DIVIDE is entered at edge k+2.
  - DONE is entered at edge k+3+q.
  - valid is high from edge k+3+q to edge k+4+q.
- us_count resolution: echo high for T µs yields us_count in T-1..T. Distance error is at most 1 cm.
- Timeout latency from start:
  - No echo: MAX_US µs plus at most 4 clk.
  - Stuck-high echo: MAX_US µs after the echo rise, plus at most 4 clk.
- busy:
  - Rises on the edge after start.
  - Falls on the edge that leaves DONE.
- Minimum cycle (start to IDLE) with a 0 µs echo is under 10 clk.

## Test plan
- Reset: assert rst asynchronously mid-MEASURE, with Echo high for 300 µs so far -> all outputs 0 and busy=0 immediately. After release, no valid pulse occurs until a new start.
- Normal range: start, Echo high 1160 µs -> one valid pulse, distance_cm=20 (19 is accepted), timeout=0, near=0. valid appears 23 to 26 clk after Echo falls.
- Near target: start, Echo high 580 µs -> distance_cm=10 (9 is accepted), near=1, timeout=0. Values hold unchanged through 1000 idle clk.
- No echo: start, Echo held low -> valid with timeout=1, distance_cm=0, near=0, at 30000 µs after start (±4 clk).
- Stuck echo: start, Echo rises 100 µs later and stays high -> valid with timeout=1 at 30000 µs after the rise. busy returns to 0.
- Stale echo and extra start:
  - Echo already high when start arrives -> no measurement until Echo falls and rises again.
  - A second start pulse during MEASURE is ignored: exactly one valid, with a result matching the first echo width.

Source files
------------

// File: rtl/echo_distance.sv
// echo_distance: measures the synchronized Echo high time in microseconds and converts it to centimetres
// Ports: clk, rst (async, active-high), start (trigger-done pulse), Echo (raw sensor pin),
//        distance_cm / timeout / near (held results), valid (one-cycle update strobe), busy (FSM not idle)
module echo_distance #(
    parameter int CLK_PER_US = 50,
    parameter int US_PER_CM  = 58,
    parameter int MAX_US     = 30000,
    parameter int NEAR_CM    = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       Echo,
    output logic [9:0] distance_cm,
    output logic       valid,
    output logic       timeout,
    output logic       near,
    output logic       busy
);
    localparam int PW = CLK_PER_US > 1 ? $clog2(CLK_PER_US) : 1;
    typedef enum logic [2:0] {IDLE, ARM, MEASURE, DIVIDE, DONE} state_t;
    state_t st, nxt;
    logic e1, echo_s, echo_p, to, tick;
    logic [PW-1:0] pre;
    logic [14:0] us, us_nx, rem;
    logic [9:0] q;
    assign tick = pre == PW'(CLK_PER_US - 1);
    assign us_nx = (tick && us != 15'(MAX_US)) ? us + 15'd1 : us;
    assign busy = st != IDLE;
    always_comb begin
        nxt = st;
        to = 1'b0;
        case (st)
            IDLE: nxt = start ? ARM : IDLE;
            ARM: begin
                // timeout has priority over a rise seen on the same edge
                to = us == 15'(MAX_US);
                nxt = to ? DONE : (echo_s && !echo_p) ? MEASURE : ARM;
            end
            MEASURE: begin
                to = us == 15'(MAX_US);
                nxt = to ? DONE : !echo_s ? DIVIDE : MEASURE;
            end
            DIVIDE: nxt = rem >= 15'(US_PER_CM) ? DIVIDE : DONE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) st <= IDLE;
        else st <= nxt;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            e1 <= 1'b0;
            echo_s <= 1'b0;
            echo_p <= 1'b0;
            pre <= '0;
            us <= '0;
            rem <= '0;
            q <= '0;
            distance_cm <= '0;
            valid <= 1'b0;
            timeout <= 1'b0;
            near <= 1'b0;
        end else begin
            e1 <= Echo;
            echo_s <= e1;
            echo_p <= echo_s;
            pre <= (nxt != st || tick) ? '0 : pre + 1'b1;
            us <= (nxt != st && (nxt == ARM || nxt == MEASURE)) ? '0 : us_nx;
            // rem takes us_nx so a tick coinciding with the echo fall is still counted
            if (st == MEASURE && nxt == DIVIDE) begin
                rem <= us_nx;
                q <= '0;
            end else if (st == DIVIDE && rem >= 15'(US_PER_CM)) begin
                rem <= rem - 15'(US_PER_CM);
                q <= q + 10'd1;
            end
            if (nxt == DONE) begin
                distance_cm <= to ? '0 : q;
                timeout <= to;
                near <= !to && q < 10'(NEAR_CM);
            end
            valid <= nxt == DONE;
        end
endmodule

// File: tb/tb_echo_distance.sv
// tb_echo_distance: scoreboard bench for echo_distance with scaled timing (2 clk per us, 3000 us limit)
module tb_echo_distance;
    localparam int CPU = 2;
    localparam int MAXU = 3000;
    typedef struct packed {
        logic [9:0] d;
        logic t;
        logic n;
    } exp_t;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, Echo = 1'b0;
    logic [9:0] distance_cm;
    logic valid, timeout, near, busy;
    int total = 0, bad = 0, cyc = 0, vcount = 0;
    exp_t sb[$];
    echo_distance #(.CLK_PER_US(CPU), .US_PER_CM(58), .MAX_US(MAXU), .NEAR_CM(20)) dut (
        .clk(clk), .rst(rst), .start(start), .Echo(Echo), .distance_cm(distance_cm),
        .valid(valid), .timeout(timeout), .near(near), .busy(busy)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask
    task automatic chk_rng(input string name, input int got, input int lo, input int hi);
        total++;
        if (got < lo || got > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
        end
    endtask
    always @(negedge clk)
        if (valid) begin
            vcount++;
            if (sb.size() == 0) chk("unexpected_valid", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("distance", int'(distance_cm), int'(e.d));
                chk("timeout", int'(timeout), int'(e.t));
                chk("near", int'(near), int'(e.n));
            end
        end
    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic pulse_start(output int t0);
        start = 1'b1;
        t0 = cyc;
        clks(1);
        start = 1'b0;
    endtask
    task automatic wait_valid(input string name, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget && at < 0; i++) begin
            @(negedge clk);
            if (valid) at = cyc;
        end
        if (at < 0) chk({name, "_no_valid"}, 0, 1);
        @(posedge clk);
        #1;
    endtask
    task automatic echo_pulse(input int clk_high, output int t_fall);
        Echo = 1'b1;
        clks(clk_high);
        Echo = 1'b0;
        t_fall = cyc;
    endtask
    initial begin
        int t0, tf, at, vc;
        exp_t e;
        clks(3);
        rst = 1'b0;
        chk("rst_distance", int'(distance_cm), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_near", int'(near), 0);
        chk("rst_busy", int'(busy), 0);
        clks(5);
        // normal range: 1160 us -> 20 cm
        e.d = 10'd20; e.t = 1'b0; e.n = 1'b0; sb.push_back(e);
        pulse_start(t0);
        chk("busy_after_start", int'(busy), 1);
        clks(10);
        echo_pulse(1160 * CPU, tf);
        wait_valid("normal", 100, at);
        chk_rng("normal_latency", at - tf, 23, 26);
        chk("busy_after_done", int'(busy), 0);
        // near target: 580 us -> 10 cm, held through idle
        e.d = 10'd10; e.t = 1'b0; e.n = 1'b1; sb.push_back(e);
        pulse_start(t0);
        clks(7);
        echo_pulse(580 * CPU, tf);
        wait_valid("near", 100, at);
        clks(1000);
        chk("hold_distance", int'(distance_cm), 10);
        chk("hold_near", int'(near), 1);
        chk("hold_timeout", int'(timeout), 0);
        // asynchronous reset mid-measure
        vc = vcount;
        pulse_start(t0);
        clks(5);
        Echo = 1'b1;
        clks(300 * CPU);
        #2 rst = 1'b1;
        #1;
        chk("amid_distance", int'(distance_cm), 0);
        chk("amid_near", int'(near), 0);
        chk("amid_timeout", int'(timeout), 0);
        chk("amid_valid", int'(valid), 0);
        chk("amid_busy", int'(busy), 0);
        clks(2);
        rst = 1'b0;
        Echo = 1'b0;
        clks(200);
        chk("no_valid_after_reset", vcount, vc);
        chk("idle_after_reset", int'(busy), 0);
        // no echo -> timeout
        e.d = 10'd0; e.t = 1'b1; e.n = 1'b0; sb.push_back(e);
        pulse_start(t0);
        wait_valid("noecho", MAXU * CPU + 50, at);
        chk_rng("noecho_latency", at - t0, MAXU * CPU - 4, MAXU * CPU + 4);
        // stuck-high echo -> timeout after the rise
        sb.push_back(e);
        pulse_start(t0);
        clks(100 * CPU);
        Echo = 1'b1;
        tf = cyc;
        wait_valid("stuck", MAXU * CPU + 50, at);
        chk_rng("stuck_latency", at - tf, MAXU * CPU, MAXU * CPU + 4);
        chk("stuck_busy", int'(busy), 0);
        // stale echo: already high at start, only a fresh rise is measured
        clks(20);
        vc = vcount;
        pulse_start(t0);
        clks(400);
        chk("stale_busy", int'(busy), 1);
        chk("stale_no_valid", vcount, vc);
        Echo = 1'b0;
        clks(10);
        e.d = 10'd10; e.t = 1'b0; e.n = 1'b1; sb.push_back(e);
        echo_pulse(580 * CPU, tf);
        wait_valid("stale", 100, at);
        // second start during MEASURE is ignored
        vc = vcount;
        e.d = 10'd20; e.t = 1'b0; e.n = 1'b0; sb.push_back(e);
        pulse_start(t0);
        clks(6);
        Echo = 1'b1;
        clks(300);
        pulse_start(t0);
        clks(1160 * CPU - 301);
        Echo = 1'b0;
        clks(200);
        chk("extra_start_one_valid", vcount - vc, 1);
        chk("extra_start_idle", int'(busy), 0);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
